id_ex_stage: RTL and testbench

- ID/EX pipeline register plus execute-side operand logic; sits directly upstream of the ALU.
- Latches decoded instruction fields from decode and generates the ALU select code.
- Forwards results from EX/MEM and MEM/WB onto the ALU operands.
- Detects load-use hazards and requests a decode stall.

---
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 tb/tb_id_ex_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU select decode, EX/MEM and MEM/WB operand
// forwarding, and load-use hazard detection toward decode.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic [XLEN-1:0]   i_imm,
    input  logic              i_alu_src,
    input  logic              i_uses_rs2,
    input  logic [1:0]        i_alu_op,
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7b5,
    input  logic              i_reg_write,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_branch,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              o_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_sel,
    output logic [XLEN-1:0]   store_data,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_reg_write,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_branch,
    output logic              o_illegal,
    output logic              hazard_stall
);

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0100;
    localparam logic [3:0] SEL_CMP = 4'b1000;

    logic [REG_AW-1:0] rs1_q, rs2_q;
    logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q;
    logic              alu_src_q;
    logic [3:0]        sel_d;
    logic              illegal_d;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

    always_comb begin
        sel_d     = SEL_ADD;
        illegal_d = 1'b0;
        case (i_alu_op)
            2'b00: sel_d = SEL_ADD;
            2'b01: sel_d = SEL_SUB;
            default: begin
                case (i_funct3)
                    3'b000:  sel_d = (i_alu_op == 2'b10 && i_funct7b5) ? SEL_SUB : SEL_ADD;
                    3'b111:  sel_d = SEL_AND;
                    3'b110:  sel_d = SEL_OR;
                    3'b010,
                    3'b011:  sel_d = SEL_CMP;
                    default: begin
                        // funct3 001/100/101: execute as add and flag illegal.
                        sel_d     = SEL_ADD;
                        illegal_d = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign hazard_stall = i_valid & o_valid & o_mem_read & (o_rd != '0) &
                          ((o_rd == i_rs1) | (i_uses_rs2 & (o_rd == i_rs2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_branch    <= 1'b0;
            o_illegal   <= 1'b0;
            o_rd        <= '0;
            alu_sel     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
        end else if (flush || (!stall && hazard_stall)) begin
            // Bubble: only the qualifying bits are cleared, data fields are don't-care.
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_branch    <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (!stall) begin
            o_valid     <= i_valid;
            o_reg_write <= i_reg_write & i_valid;
            o_mem_read  <= i_mem_read & i_valid;
            o_mem_write <= i_mem_write & i_valid;
            o_branch    <= i_branch & i_valid;
            o_illegal   <= illegal_d & i_valid;
            o_rd        <= i_rd;
            alu_sel     <= sel_d;
            rs1_q       <= i_rs1;
            rs2_q       <= i_rs2;
            rs1_data_q  <= i_rs1_data;
            rs2_data_q  <= i_rs2_data;
            imm_q       <= i_imm;
            alu_src_q   <= i_alu_src;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs1_q)
            fwd_rs1 = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs1_q)
            fwd_rs1 = memwb_result;
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs2_q)
            fwd_rs2 = exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs2_q)
            fwd_rs2 = memwb_result;
    end

    assign alu_a      = fwd_rs1;
    assign alu_b      = alu_src_q ? imm_q : fwd_rs2;
    assign store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed stimulus queues expected values
// tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic [31:0] i_rs1_data, i_rs2_data, i_imm;
    logic        i_alu_src, i_uses_rs2;
    logic [1:0]  i_alu_op;
    logic [2:0]  i_funct3;
    logic        i_funct7b5;
    logic        i_reg_write, i_mem_read, i_mem_write, i_branch;
    logic        stall, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        o_valid;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_sel;
    logic [4:0]  o_rd;
    logic        o_reg_write, o_mem_read, o_mem_write, o_branch, o_illegal;
    logic        hazard_stall;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_alu_src(i_alu_src), .i_uses_rs2(i_uses_rs2), .i_alu_op(i_alu_op),
        .i_funct3(i_funct3), .i_funct7b5(i_funct7b5),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_branch(i_branch),
        .stall(stall), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .o_valid(o_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .store_data(store_data), .o_rd(o_rd), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_branch(o_branch),
        .o_illegal(o_illegal), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    localparam int S_VALID = 0, S_SEL = 1, S_A = 2, S_B = 3, S_ILL = 4,
                   S_HAZ = 5, S_STD = 6, S_RW = 7;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_VALID: return {31'd0, o_valid};
            S_SEL:   return {28'd0, alu_sel};
            S_A:     return alu_a;
            S_B:     return alu_b;
            S_ILL:   return {31'd0, o_illegal};
            S_HAZ:   return {31'd0, hazard_stall};
            S_STD:   return store_data;
            default: return {31'd0, o_reg_write};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (observe(e.sel) !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, observe(e.sel), e.exp, cyc);
            end
        end
    end

    task automatic expect_at(int dcyc, string name, int sel, logic [31:0] v);
        sb.push_back('{cyc + dcyc, name, sel, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_rs1 = 0; i_rs2 = 0; i_rd = 0;
        i_rs1_data = 0; i_rs2_data = 0; i_imm = 0;
        i_alu_src = 0; i_uses_rs2 = 0; i_alu_op = 0; i_funct3 = 0; i_funct7b5 = 0;
        i_reg_write = 0; i_mem_read = 0; i_mem_write = 0; i_branch = 0;
        stall = 0; flush = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    endtask

    task automatic instr(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2);
        i_valid = 1; i_alu_op = op; i_funct3 = f3; i_funct7b5 = f7;
        i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_rs1_data = d1; i_rs2_data = d2;
        i_imm = 0; i_alu_src = 0; i_uses_rs2 = 1;
        i_reg_write = 1; i_mem_read = 0; i_mem_write = 0; i_branch = 0;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] sel;
        logic       ill;
        string      name;
    } dec_t;

    dec_t dec_tab[8];

    initial begin
        dec_tab[0] = '{2'b10, 3'b000, 1'b0, 4'b0010, 1'b0, "add"};
        dec_tab[1] = '{2'b10, 3'b000, 1'b1, 4'b0100, 1'b0, "sub"};
        dec_tab[2] = '{2'b10, 3'b111, 1'b0, 4'b0000, 1'b0, "and"};
        dec_tab[3] = '{2'b10, 3'b110, 1'b0, 4'b0001, 1'b0, "or"};
        dec_tab[4] = '{2'b10, 3'b011, 1'b0, 4'b1000, 1'b0, "sltu"};
        dec_tab[5] = '{2'b01, 3'b000, 1'b0, 4'b0100, 1'b0, "branch"};
        dec_tab[6] = '{2'b11, 3'b000, 1'b1, 4'b0010, 1'b0, "addi_f7"};
        dec_tab[7] = '{2'b10, 3'b001, 1'b0, 4'b0010, 1'b1, "sll_illegal"};

        idle_inputs();
        rst_n = 0;
        step(); step();
        expect_at(0, "rst_valid", S_VALID, 0);
        expect_at(0, "rst_sel", S_SEL, 0);
        expect_at(0, "rst_rw", S_RW, 0);
        expect_at(0, "rst_ill", S_ILL, 0);
        expect_at(0, "rst_a", S_A, 0);
        step();
        rst_n = 1;
        step();

        // Basic ADD with operand pass-through
        instr(2'b10, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7);
        expect_at(1, "add_valid", S_VALID, 1);
        expect_at(1, "add_sel", S_SEL, 32'h2);
        expect_at(1, "add_a", S_A, 32'd5);
        expect_at(1, "add_b", S_B, 32'd7);
        step();

        foreach (dec_tab[k]) begin
            instr(dec_tab[k].op, dec_tab[k].f3, dec_tab[k].f7, 5'd1, 5'd2, 5'd5,
                  32'h100 + k, 32'h200 + k);
            expect_at(1, {dec_tab[k].name, "_sel"}, S_SEL, {28'd0, dec_tab[k].sel});
            expect_at(1, {dec_tab[k].name, "_ill"}, S_ILL, {31'd0, dec_tab[k].ill});
            step();
        end

        // Immediate operand B; store data still carries rs2
        instr(2'b11, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'h11, 32'h99);
        i_alu_src = 1; i_imm = 32'h10;
        expect_at(1, "imm_b", S_B, 32'h10);
        expect_at(1, "imm_store", S_STD, 32'h99);
        step();

        // Invalid instruction: control bits masked
        instr(2'b10, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2);
        i_valid = 0;
        expect_at(1, "inv_valid", S_VALID, 0);
        expect_at(1, "inv_rw", S_RW, 0);
        step();

        // Forwarding on a held instruction
        instr(2'b10, 3'b000, 1'b0, 5'd3, 5'd6, 5'd7, 32'h11, 32'h22);
        step();
        stall = 1; i_valid = 0;
        exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'hAA;
        memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'hBB;
        expect_at(0, "fwd_exmem_prio", S_A, 32'hAA);
        expect_at(0, "fwd_rs2_none", S_B, 32'h22);
        step();
        exmem_reg_write = 0;
        expect_at(0, "fwd_memwb", S_A, 32'hBB);
        step();
        memwb_reg_write = 0;
        exmem_rd = 6; exmem_reg_write = 1; exmem_result = 32'hCC;
        expect_at(0, "fwd_none_a", S_A, 32'h11);
        expect_at(0, "fwd_rs2_b", S_B, 32'hCC);
        expect_at(0, "fwd_rs2_store", S_STD, 32'hCC);
        step();
        exmem_reg_write = 0;
        stall = 0;
        instr(2'b10, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'h33, 32'h44);
        step();
        stall = 1; i_valid = 0;
        exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hAA;
        memwb_rd = 0; memwb_reg_write = 1; memwb_result = 32'hBB;
        expect_at(0, "fwd_x0_a", S_A, 32'h33);
        expect_at(0, "fwd_x0_b", S_B, 32'h44);
        step();
        exmem_reg_write = 0; memwb_reg_write = 0; stall = 0;

        // Load-use hazard on rs2
        instr(2'b00, 3'b010, 1'b0, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0);
        i_mem_read = 1; i_alu_src = 1;
        step();
        instr(2'b10, 3'b000, 1'b0, 5'd9, 5'd4, 5'd8, 32'h1, 32'h2);
        expect_at(0, "haz_set", S_HAZ, 1);
        step();
        expect_at(0, "haz_clear", S_HAZ, 0);
        expect_at(0, "haz_bubble", S_VALID, 0);
        step();
        expect_at(0, "haz_reissue", S_VALID, 1);
        expect_at(0, "haz_reissue_sel", S_SEL, 32'h2);
        // Same register on rs2, but the consumer does not read rs2
        instr(2'b00, 3'b010, 1'b0, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0);
        i_mem_read = 1;
        step();
        instr(2'b11, 3'b000, 1'b0, 5'd9, 5'd4, 5'd8, 32'h1, 32'h2);
        i_uses_rs2 = 0;
        expect_at(0, "haz_no_rs2", S_HAZ, 0);
        step();

        // Stall holds everything; flush beats stall
        instr(2'b10, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7);
        step();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            instr(2'b01, 3'b111, 1'b1, 5'd10 + 5'(k), 5'd11, 5'd12, 32'h77 + k, 32'h88);
            i_valid = k[0];
            expect_at(1, "stall_valid", S_VALID, 1);
            expect_at(1, "stall_sel", S_SEL, 32'h2);
            expect_at(1, "stall_a", S_A, 32'd5);
            step();
        end
        flush = 1;
        expect_at(1, "flush_valid", S_VALID, 0);
        expect_at(1, "flush_rw", S_RW, 0);
        step();
        flush = 0; stall = 0;

        // Asynchronous reset while stalled
        instr(2'b10, 3'b000, 1'b1, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7);
        expect_at(1, "pre_rst_valid", S_VALID, 1);
        expect_at(1, "pre_rst_sel", S_SEL, 32'h4);
        step();
        stall = 1;
        step();
        #1 rst_n = 0;
        expect_at(0, "arst_valid", S_VALID, 0);
        expect_at(0, "arst_rw", S_RW, 0);
        expect_at(0, "arst_sel", S_SEL, 0);
        step(); step();
        rst_n = 1; idle_inputs();

        for (int k = 0; k < 50 && sb.size() > 0; k++) step();
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
